lsmitll_jtlt_rx: RTL and testbench

//   Clocked receiver directly downstream of the toggle-encoded JTL cell model (every edge on its

---
 rtl/lsmitll_rx_pkg.sv | 17 +
 rtl/lsmitll_jtlt_rx_if.sv | 22 ++
 rtl/lsmitll_toggle_edge.sv | 26 ++
 rtl/lsmitll_jtlt_rx.sv | 124 ++++++++++++
 tb/tb_lsmitll_jtlt_rx.sv | 135 +++++++++++++
 5 files changed

// File: rtl/lsmitll_rx_pkg.sv
// rtl/lsmitll_rx_pkg.sv - shared types and helpers for the toggle-encoded JTL receiver
package lsmitll_rx_pkg;

    localparam int RX_STATE_W = 2;

    typedef enum logic [RX_STATE_W-1:0] {
        RX_EMPTY = 2'd0,
        RX_FULL  = 2'd1,
        RX_ERROR = 2'd2
    } rx_state_t;

    // A zero guard still needs a one-bit counter so the datapath stays well formed.
    function automatic int guard_w(input int guard_cycles);
        return (guard_cycles > 0) ? $clog2(guard_cycles + 1) : 1;
    endfunction

endpackage

// File: rtl/lsmitll_jtlt_rx_if.sv
// rtl/lsmitll_jtlt_rx_if.sv - pulse/strobe bundle between a harness and the JTL receiver
interface lsmitll_jtlt_rx_if #(
    parameter int CNT_W = 16
) ();
    logic             a;
    logic             readout;
    logic             clr_err;
    logic             q;
    logic             q_tog;
    logic             err;
    logic [CNT_W-1:0] pulse_cnt;

    modport master (
        output a, readout, clr_err,
        input  q, q_tog, err, pulse_cnt
    );

    modport slave (
        input  a, readout, clr_err,
        output q, q_tog, err, pulse_cnt
    );
endinterface

// File: rtl/lsmitll_toggle_edge.sv
// rtl/lsmitll_toggle_edge.sv - turns each edge of a toggle-encoded line into a one-cycle pulse
module lsmitll_toggle_edge (
    input  logic clk,
    input  logic rst,
    input  logic a,
    output logic pulse
);
    logic a_d_q;
    logic a_d_d;

    always_comb begin
        a_d_d = a;
    end

    // Reset captures the live level so an already-high line is not seen as a pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_d_q <= a;
        end else begin
            a_d_q <= a_d_d;
        end
    end

    assign pulse = a ^ a_d_q;

endmodule

// File: rtl/lsmitll_jtlt_rx.sv
// rtl/lsmitll_jtlt_rx.sv - single-pulse RSFQ DFF analogue with spacing guard and pulse counter
module lsmitll_jtlt_rx
    import lsmitll_rx_pkg::*;
#(
    parameter int GUARD_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    lsmitll_jtlt_rx_if.slave  bus
);
    localparam int            GW         = guard_w(GUARD_CYCLES);
    localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYCLES);

    rx_state_t        state_q, state_d;
    logic [GW-1:0]    guard_q, guard_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             q_q, q_d;
    logic             tog_q, tog_d;
    logic             pulse;
    logic             guard_ok;
    logic             accept;
    logic             emit;

    lsmitll_toggle_edge u_edge (
        .clk   (clk),
        .rst   (rst),
        .a     (bus.a),
        .pulse (pulse)
    );

    assign guard_ok = (guard_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RX_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Readout is judged against the registered state, so a pulse arriving with it is seen separately.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RX_EMPTY: begin
                if (pulse) begin
                    state_d = guard_ok ? RX_FULL : RX_ERROR;
                end
            end
            RX_FULL: begin
                if (pulse) begin
                    if (!(bus.readout && guard_ok)) begin
                        state_d = RX_ERROR;
                    end
                end else if (bus.readout) begin
                    state_d = RX_EMPTY;
                end
            end
            RX_ERROR: begin
                if (bus.clr_err) begin
                    state_d = RX_EMPTY;
                end
            end
            default: state_d = RX_EMPTY;
        endcase
    end

    // A readout that coincides with a violation is swallowed: the error wins and q stays low.
    always_comb begin
        accept = 1'b0;
        emit   = 1'b0;
        unique case (state_q)
            RX_EMPTY: begin
                accept = pulse && guard_ok;
            end
            RX_FULL: begin
                emit   = bus.readout && !(pulse && !guard_ok);
                accept = bus.readout && pulse && guard_ok;
            end
            default: begin
                accept = 1'b0;
                emit   = 1'b0;
            end
        endcase
    end

    always_comb begin
        q_d   = emit;
        tog_d = tog_q ^ emit;
        if (accept) begin
            guard_d = GUARD_LOAD;
        end else if (state_q == RX_ERROR || guard_ok) begin
            guard_d = '0;
        end else begin
            guard_d = guard_q - GW'(1);
        end
        if (accept && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            guard_q <= '0;
            cnt_q   <= '0;
            q_q     <= 1'b0;
            tog_q   <= 1'b0;
        end else begin
            guard_q <= guard_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            tog_q   <= tog_d;
        end
    end

    assign bus.q         = q_q;
    assign bus.q_tog     = tog_q;
    assign bus.err       = (state_q == RX_ERROR);
    assign bus.pulse_cnt = cnt_q;

endmodule

// File: tb/tb_lsmitll_jtlt_rx.sv
// tb/tb_lsmitll_jtlt_rx.sv - directed scoreboard bench for the JTL receiver
module tb_lsmitll_jtlt_rx;

    typedef struct packed {
        logic       q;
        logic       tog;
        logic       err;
        logic [3:0] cnt;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    exp_t   sb[$];
    int     vectors     = 0;
    int     miscompares = 0;
    int     step_no     = 0;
    string  tag         = "init";
    logic   t;
    int     c;

    lsmitll_jtlt_rx_if #(.CNT_W(4)) bus ();

    lsmitll_jtlt_rx #(
        .GUARD_CYCLES (2),
        .CNT_W        (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Drive one cycle of stimulus, queue what the outputs must show after the edge, then check.
    task automatic cyc(input logic r, input logic tg, input logic rd, input logic clr,
                       input logic eq, input logic et, input logic ee, input logic [3:0] ec);
        exp_t e;
        exp_t o;
        e.q   = eq;
        e.tog = et;
        e.err = ee;
        e.cnt = ec;
        rst = r;
        if (tg) bus.a = ~bus.a;
        bus.readout = rd;
        bus.clr_err = clr;
        sb.push_back(e);
        @(posedge clk);
        #1;
        step_no++;
        e = sb.pop_front();
        o = {bus.q, bus.q_tog, bus.err, bus.pulse_cnt};
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s step %0d: observed q=%b tog=%b err=%b cnt=%0d, expected q=%b tog=%b err=%b cnt=%0d",
                   tag, step_no, o.q, o.tog, o.err, o.cnt, e.q, e.tog, e.err, e.cnt);
        end
    endtask

    initial begin
        bus.a       = 1'b1;
        bus.readout = 1'b0;
        bus.clr_err = 1'b0;

        tag = "t1_reset_a_high";
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0, 0);

        tag = "t2_store_readout";
        cyc(0, 1, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 1, 1, 0, 1);
        cyc(0, 0, 0, 0, 0, 1, 0, 1);

        tag = "t3_guard_violation";
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 1);
        cyc(0, 1, 1, 0, 0, 0, 1, 1);
        cyc(0, 1, 1, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 0, 1, 1);
        cyc(0, 1, 0, 1, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 0, 0, 2);

        tag = "t4_overrun";
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 0, 1, 1);
        cyc(0, 0, 1, 0, 0, 0, 1, 1);

        tag = "t5_pass_through";
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 1, 1, 0, 1, 1, 0, 2);
        cyc(0, 0, 0, 0, 0, 1, 0, 2);
        cyc(0, 0, 0, 0, 0, 1, 0, 2);
        cyc(0, 0, 1, 0, 1, 0, 0, 2);
        cyc(0, 0, 0, 0, 0, 0, 0, 2);
        tag = "t5_empty_pulse_and_readout";
        cyc(0, 1, 1, 0, 0, 0, 0, 3);
        cyc(0, 0, 0, 0, 0, 0, 0, 3);
        cyc(0, 0, 1, 0, 1, 1, 0, 3);

        tag = "t6_saturate";
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        t = 1'b0;
        for (int i = 0; i < 20; i++) begin
            c = (i + 1 > 15) ? 15 : i + 1;
            cyc(0, 1, 0, 0, 0, t, 0, 4'(c));
            t = ~t;
            cyc(0, 0, 1, 0, 1, t, 0, 4'(c));
            cyc(0, 0, 0, 0, 0, t, 0, 4'(c));
        end
        tag = "t6_reset_mid_guard";
        cyc(0, 1, 0, 0, 0, t, 0, 15);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
